// File: rtl/scope_pkg.sv
// Shared constants for the scope channel arbiter: channel modes, FSM state
// encodings and the default sample width.
package scope_pkg;

    localparam int unsigned DATA_W_DEF = 8;

    localparam logic [1:0] MODE_CH0  = 2'd0;
    localparam logic [1:0] MODE_CH1  = 2'd1;
    localparam logic [1:0] MODE_BOTH = 2'd2;
    localparam logic [1:0] MODE_HOLD = 2'd3;

    localparam logic ST_RUN   = 1'b0;
    localparam logic ST_FLUSH = 1'b1;

    // Per-channel enable mask for a mode, bit n = channel n.
    function automatic logic [1:0] mode_en(input logic [1:0] m);
        case (m)
            MODE_CH0:  return 2'b01;
            MODE_CH1:  return 2'b10;
            MODE_BOTH: return 2'b11;
            default:   return 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/scope_chan_hold.sv
// One-deep pending-sample holder for a single ADC channel, with enable gating
// and sticky overrun detection.
module scope_chan_hold
    import scope_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stb,
    input  logic [DATA_W-1:0] data,
    input  logic              en,
    input  logic              grant,
    input  logic              flush,
    input  logic              clr_ovr,
    output logic [DATA_W-1:0] hold,
    output logic              pend,
    output logic              ovr
);

    logic acc;
    logic ovr_set;

    assign acc     = stb & en & ~flush;
    // A sample being granted this cycle frees the slot, so a fresh strobe is not an overrun.
    assign ovr_set = acc & pend & ~grant;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold <= '0;
            pend <= 1'b0;
        end else if (flush) begin
            pend <= 1'b0;
        end else if (acc) begin
            hold <= data;
            pend <= 1'b1;
        end else if (grant) begin
            pend <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovr <= 1'b0;
        end else if (ovr_set) begin
            ovr <= 1'b1;
        end else if (clr_ovr) begin
            ovr <= 1'b0;
        end
    end

endmodule

// File: rtl/scope_chan_arbiter.sv
// Shares the 8-bit capture sample path between two ADC channels: per-channel
// pending holders, round-robin grant, registered valid/ready output, mode flush.
module scope_chan_arbiter
    import scope_pkg::*;
#(
    parameter int unsigned DATA_W   = DATA_W_DEF,
    parameter int unsigned RR_START = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] ch0_data,
    input  logic              ch0_stb,
    input  logic [DATA_W-1:0] ch1_data,
    input  logic              ch1_stb,
    input  logic [1:0]        mode,
    input  logic              clr_ovr,
    output logic [DATA_W-1:0] out_data,
    output logic              out_ch,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [1:0]        ovr,
    output logic              busy
);

    // last_grant starts opposite RR_START so RR_START wins the first tie.
    localparam logic LAST_RST = (RR_START == 0) ? 1'b1 : 1'b0;

    logic              state;
    logic [1:0]        mode_q;
    logic              last_grant;
    logic [1:0]        en;
    logic [1:0]        pend;
    logic [1:0]        grant;
    logic [DATA_W-1:0] hold0;
    logic [DATA_W-1:0] hold1;
    logic              flush;
    logic              can_load;
    logic              ld;
    logic              win;

    assign en       = mode_en(mode_q);
    assign flush    = (state == ST_FLUSH);
    assign can_load = ~out_valid | out_ready;
    assign ld       = ~flush & can_load & (pend[0] | pend[1]);
    assign win      = (pend[0] & pend[1]) ? ~last_grant : pend[1];
    assign grant    = {ld & win, ld & ~win};
    assign busy     = pend[0] | pend[1] | out_valid;

    scope_chan_hold #(.DATA_W(DATA_W)) u_hold0 (
        .clk     (clk),
        .rst     (rst),
        .stb     (ch0_stb),
        .data    (ch0_data),
        .en      (en[0]),
        .grant   (grant[0]),
        .flush   (flush),
        .clr_ovr (clr_ovr),
        .hold    (hold0),
        .pend    (pend[0]),
        .ovr     (ovr[0])
    );

    scope_chan_hold #(.DATA_W(DATA_W)) u_hold1 (
        .clk     (clk),
        .rst     (rst),
        .stb     (ch1_stb),
        .data    (ch1_data),
        .en      (en[1]),
        .grant   (grant[1]),
        .flush   (flush),
        .clr_ovr (clr_ovr),
        .hold    (hold1),
        .pend    (pend[1]),
        .ovr     (ovr[1])
    );

    // mode_q powers up as HOLD so nothing is accepted until a flush has latched the live mode.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_RUN;
            mode_q <= MODE_HOLD;
        end else begin
            case (state)
                ST_RUN: begin
                    if (mode != mode_q) begin
                        state <= ST_FLUSH;
                    end
                end
                default: begin
                    mode_q <= mode;
                    state  <= ST_RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data   <= '0;
            out_ch     <= 1'b0;
            out_valid  <= 1'b0;
            last_grant <= LAST_RST;
        end else if (ld) begin
            out_data   <= win ? hold1 : hold0;
            out_ch     <= win;
            out_valid  <= 1'b1;
            last_grant <= win;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_scope_chan_arbiter.sv
// Scoreboard bench for scope_chan_arbiter: directed stimulus pushes expected
// samples, a monitor pops them on every accepted output beat.
module tb_scope_chan_arbiter;
    import scope_pkg::*;

    localparam int unsigned DW = 8;

    typedef struct {
        logic [DW-1:0] d;
        logic          c;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] ch0_data = '0;
    logic          ch0_stb = 1'b0;
    logic [DW-1:0] ch1_data = '0;
    logic          ch1_stb = 1'b0;
    logic [1:0]    mode = MODE_BOTH;
    logic          clr_ovr = 1'b0;
    logic [DW-1:0] out_data;
    logic          out_ch;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [1:0]    ovr;
    logic          busy;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    scope_chan_arbiter #(.DATA_W(DW), .RR_START(0)) dut (
        .clk       (clk),
        .rst       (rst),
        .ch0_data  (ch0_data),
        .ch0_stb   (ch0_stb),
        .ch1_data  (ch1_data),
        .ch1_stb   (ch1_stb),
        .mode      (mode),
        .clr_ovr   (clr_ovr),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ovr       (ovr),
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic strobe(input logic s0, input logic [DW-1:0] d0,
                          input logic s1, input logic [DW-1:0] d1);
        ch0_stb  = s0;
        ch0_data = d0;
        ch1_stb  = s1;
        ch1_data = d1;
        tick(1);
        ch0_stb = 1'b0;
        ch1_stb = 1'b0;
    endtask

    task automatic push(input logic [DW-1:0] d, input logic c);
        exp_t e;
        e.d = d;
        e.c = c;
        q.push_back(e);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        chk("rst_valid", {31'd0, out_valid}, 0);
        chk("rst_data", {24'd0, out_data}, 0);
        chk("rst_ch", {31'd0, out_ch}, 0);
        chk("rst_ovr", {30'd0, ovr}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        rst = 1'b0;
        tick(3);
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst && out_valid && out_ready) begin
            chk("out_expected", {31'd0, q.size() != 0}, 1);
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("out_data", {24'd0, out_data}, {24'd0, e.d});
                chk("out_ch", {31'd0, out_ch}, {31'd0, e.c});
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog timeout at %0t", $time);
        $fatal(1);
    end

    initial begin
        // single sample latency and busy
        mode      = MODE_BOTH;
        out_ready = 1'b1;
        do_reset();
        push(8'h11, 1'b0);
        strobe(1'b1, 8'h11, 1'b0, 8'h00);
        chk("t1_busy_pend", {31'd0, busy}, 1);
        chk("t1_valid_early", {31'd0, out_valid}, 0);
        tick(1);
        chk("t1_valid", {31'd0, out_valid}, 1);
        chk("t1_data", {24'd0, out_data}, 32'h11);
        tick(1);
        chk("t1_valid_drop", {31'd0, out_valid}, 0);
        chk("t1_busy_drop", {31'd0, busy}, 0);

        // simultaneous strobes, RR_START=0 favours ch0, back-to-back
        do_reset();
        push(8'hA0, 1'b0);
        push(8'hB1, 1'b1);
        strobe(1'b1, 8'hA0, 1'b1, 8'hB1);
        chk("t2_valid_early", {31'd0, out_valid}, 0);
        tick(1);
        chk("t2_first_ch", {31'd0, out_ch}, 0);
        tick(1);
        chk("t2_no_gap", {31'd0, out_valid}, 1);
        chk("t2_second_ch", {31'd0, out_ch}, 1);
        tick(1);
        chk("t2_idle", {31'd0, out_valid}, 0);
        chk("t2_ovr", {30'd0, ovr}, 0);

        // backpressure and overrun on ch1
        mode = MODE_CH1;
        tick(3);
        out_ready = 1'b0;
        push(8'h01, 1'b1);
        strobe(1'b0, 8'h00, 1'b1, 8'h01);
        tick(1);
        strobe(1'b0, 8'h00, 1'b1, 8'h02);
        chk("t3_no_ovr", {30'd0, ovr}, 0);
        strobe(1'b0, 8'h00, 1'b1, 8'h03);
        chk("t3_ovr", {30'd0, ovr}, 2);
        chk("t3_held", {24'd0, out_data}, 32'h01);
        chk("t3_held_valid", {31'd0, out_valid}, 1);
        push(8'h03, 1'b1);
        out_ready = 1'b1;
        tick(3);
        chk("t3_idle", {31'd0, out_valid}, 0);
        clr_ovr = 1'b1;
        tick(1);
        clr_ovr = 1'b0;
        chk("t3_clr", {30'd0, ovr}, 0);

        // disabled strobe ignored; mode change flushes pending sample
        mode = MODE_CH0;
        tick(3);
        strobe(1'b0, 8'h00, 1'b1, 8'h55);
        tick(2);
        chk("t4_ign_valid", {31'd0, out_valid}, 0);
        chk("t4_ign_busy", {31'd0, busy}, 0);
        chk("t4_ign_ovr", {30'd0, ovr}, 0);
        mode = MODE_CH1;
        strobe(1'b1, 8'h66, 1'b0, 8'h00);
        chk("t4_pend", {31'd0, busy}, 1);
        tick(1);
        chk("t4_flushed", {31'd0, busy}, 0);
        tick(2);
        chk("t4_no_out", {31'd0, out_valid}, 0);

        // clr_ovr loses to a simultaneous new overrun
        mode = MODE_BOTH;
        tick(3);
        out_ready = 1'b0;
        push(8'h21, 1'b0);
        strobe(1'b1, 8'h21, 1'b0, 8'h00);
        tick(1);
        strobe(1'b1, 8'h22, 1'b0, 8'h00);
        strobe(1'b1, 8'h23, 1'b0, 8'h00);
        strobe(1'b0, 8'h00, 1'b1, 8'h31);
        strobe(1'b0, 8'h00, 1'b1, 8'h32);
        chk("t5_ovr11", {30'd0, ovr}, 3);
        clr_ovr = 1'b1;
        strobe(1'b1, 8'h24, 1'b0, 8'h00);
        clr_ovr = 1'b0;
        chk("t5_ovr01", {30'd0, ovr}, 1);
        push(8'h32, 1'b1);
        push(8'h24, 1'b0);
        out_ready = 1'b1;
        tick(4);
        chk("t5_idle", {31'd0, out_valid}, 0);
        chk("t5_ovr_keep", {30'd0, ovr}, 1);

        // async reset mid-stream, then first tie follows RR_START
        out_ready = 1'b0;
        strobe(1'b1, 8'h41, 1'b0, 8'h00);
        tick(1);
        strobe(1'b1, 8'h42, 1'b1, 8'h52);
        chk("t6_pre_valid", {31'd0, out_valid}, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_async_valid", {31'd0, out_valid}, 0);
        chk("t6_async_busy", {31'd0, busy}, 0);
        chk("t6_async_ovr", {30'd0, ovr}, 0);
        tick(1);
        rst = 1'b0;
        tick(3);
        out_ready = 1'b1;
        push(8'h61, 1'b0);
        push(8'h71, 1'b1);
        strobe(1'b1, 8'h61, 1'b1, 8'h71);
        tick(4);
        chk("t6_idle", {31'd0, out_valid}, 0);

        chk("drain", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
